// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: loads a byte into an external 8-bit PISO, times each
// bit with a baud counter, strobes the PISO and frames start/data/stop on tx.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [7:0] piso_din,
    output logic       piso_load,
    output logic       piso_shift,
    input  logic       piso_y,
    output logic       tx
);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    localparam logic [15:0] CNT_MAX   = 16'(CLKS_PER_BIT - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    state_t      state, state_nx;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic        stop_idx;
    logic [7:0]  data_reg;
    logic        bit_end;

    assign bit_end  = (cnt == CNT_MAX);
    assign piso_din = data_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (tx_start) state_nx = LOAD;
            LOAD:    state_nx = START;
            START:   if (bit_end) state_nx = DATA;
            DATA:    if (bit_end && bit_idx == 3'd7) state_nx = STOP;
            STOP:    if (bit_end && stop_idx == STOP_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decode registered state only; piso_y reaches tx solely in DATA
    // because the PISO output is undefined until the first shift.
    always_comb begin
        tx         = 1'b1;
        tx_busy    = 1'b1;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        case (state)
            IDLE:  tx_busy = 1'b0;
            LOAD:  piso_load = 1'b1;
            START: begin
                tx         = 1'b0;
                piso_shift = bit_end;
            end
            DATA: begin
                tx         = piso_y;
                piso_shift = bit_end && (bit_idx != 3'd7);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            data_reg <= '0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= (state == STOP) && bit_end && (stop_idx == STOP_LAST);
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (tx_start) data_reg <= tx_data;
                end
                START, DATA, STOP: cnt <= bit_end ? '0 : cnt + 16'd1;
                default: cnt <= '0;
            endcase
            if (state == START && bit_end) bit_idx <= '0;
            if (state == DATA && bit_end) begin
                if (bit_idx != 3'd7) bit_idx  <= bit_idx + 3'd1;
                else                 stop_idx <= 1'b0;
            end
            if (state == STOP && bit_end && stop_idx != STOP_LAST)
                stop_idx <= stop_idx + 1'b1;
        end
    end

endmodule
